// File: rtl/instr_fetch_unit_pkg.sv
// Definitions shared by the fetch unit and the datapath control: FSM state encoding and the
// default end-of-program marker.
package instr_fetch_unit_pkg;

  localparam int unsigned InstrW = 32;
  localparam logic [InstrW-1:0] DefaultEopWord = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } fetch_state_e;

  function automatic logic state_busy(fetch_state_e st);
    return (st == StRun) || (st == StDrain);
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Program-load, control and instruction-stream signals of the fetch unit.
// The slave modport is the fetch unit; the master modport is the program loader / consumer.
interface instr_fetch_unit_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              start;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic [31:0]       instr_o;
  logic [ADDR_W-1:0] instr_pc_o;
  logic              instr_valid_o;
  logic              instr_ready_i;
  logic              busy_o;
  logic              done_o;

  modport master (
    output wr_en, wr_addr, wr_data, start, redirect_valid, redirect_pc, instr_ready_i,
    input  instr_o, instr_pc_o, instr_valid_o, busy_o, done_o
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, redirect_valid, redirect_pc, instr_ready_i,
    output instr_o, instr_pc_o, instr_valid_o, busy_o, done_o
  );
endinterface

// File: rtl/instr_fetch_unit_fetch_queue.sv
// fetch_queue: small FIFO (depth 1 or 2) of {pc, instr} entries; entry 0 is the head.
module instr_fetch_unit_fetch_queue #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 40,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);
  localparam int unsigned StoreW = Depth * Width;

  logic [StoreW-1:0] store_q, store_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              do_pop;
  int unsigned       wr_sh;

  assign do_pop = pop_i & (count_q != '0);

  always_comb begin
    store_d = store_q;
    count_d = count_q;
    wr_sh   = (32'(count_q) - 32'(do_pop)) * Width;
    if (flush_i) begin
      count_d = '0;
    end else begin
      if (do_pop) store_d = store_q >> Width;
      // New entry goes just behind whatever survives this cycle's pop.
      if (push_i) begin
        store_d = (store_d & ~(StoreW'({Width{1'b1}}) << wr_sh)) | (StoreW'(data_i) << wr_sh);
      end
      count_d = count_q + CntW'(push_i) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      store_q <= '0;
      count_q <= '0;
    end else begin
      store_q <= store_d;
      count_q <= count_d;
    end
  end

  assign data_o  = store_q[Width-1:0];
  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch front end: program memory, PC, one-deep read pipeline and output queue.
// Define FETCH_SKID_EN for a 2-entry queue (1 instr/cycle); default is 1 entry (1 per 2 cycles).
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [InstrW-1:0] EOP_WORD = DefaultEopWord
) (
  input logic               clk,
  input logic               rst_n,
  instr_fetch_unit_if.slave bus
);
`ifdef FETCH_SKID_EN
  localparam int unsigned QueueDepth = 2;
`else
  localparam int unsigned QueueDepth = 1;
`endif
  localparam int unsigned CntW   = $clog2(QueueDepth + 1);
  localparam int unsigned EntryW = ADDR_W + InstrW;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, req_pc_q, req_pc_d;
  logic              inflight_q, inflight_d;
  logic [InstrW-1:0] rdata_q;
  logic [InstrW-1:0] mem_q [2**ADDR_W];

  logic              busy, done, transfer, redirect, flush;
  logic              landing, eop_land, issue, drained, q_push;
  logic              q_full, q_empty;
  logic [CntW-1:0]   q_count;
  logic [EntryW-1:0] q_head;
  int unsigned       free_slots;

  assign transfer = ~q_empty & bus.instr_ready_i;
  assign redirect = bus.redirect_valid & busy;
  assign flush    = bus.start | redirect;
  // A flush kills the read in flight; nothing lands outside RUN.
  assign landing  = inflight_q & (state_q == StRun) & ~flush;
  assign eop_land = landing & (rdata_q == EOP_WORD);
  assign q_push   = landing & (~q_full | transfer);

  assign free_slots = QueueDepth - 32'(q_count) + 32'(transfer);
  assign issue   = (state_q == StRun) & ~flush & ~eop_land & (free_slots > 32'(inflight_q));
  assign drained = ((32'(q_count) - 32'(transfer)) == 0) & ~inflight_q;

  always_comb begin
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = issue;
    if (bus.start) begin
      pc_d = RESET_PC;
    end else if (redirect) begin
      pc_d = bus.redirect_pc;
    end else if (issue) begin
      pc_d     = pc_q + ADDR_W'(1);
      req_pc_d = pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
    end
  end

  // Memory contents survive reset; loads are only accepted while idle.
  always_ff @(posedge clk) begin
    if (bus.wr_en && !busy) mem_q[bus.wr_addr] <= bus.wr_data;
    if (issue) rdata_q <= mem_q[pc_q];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: if (bus.start) state_d = StRun;
      StRun: begin
        if (flush)         state_d = StRun;
        else if (eop_land) state_d = StDrain;
      end
      StDrain: begin
        if (flush)        state_d = StRun;
        else if (drained) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = state_busy(state_q);
    done = (state_q == StDone);
  end

  instr_fetch_unit_fetch_queue #(
    .Depth(QueueDepth),
    .Width(EntryW)
  ) u_fetch_queue (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (q_push),
    .data_i ({req_pc_q, rdata_q}),
    .pop_i  (transfer),
    .flush_i(flush),
    .data_o (q_head),
    .full_o (q_full),
    .empty_o(q_empty),
    .count_o(q_count)
  );

  assign bus.instr_valid_o = ~q_empty;
  assign bus.instr_o       = q_empty ? '0 : q_head[InstrW-1:0];
  assign bus.instr_pc_o    = q_empty ? '0 : q_head[EntryW-1:InstrW];
  assign bus.busy_o        = busy;
  assign bus.done_o        = done;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a memory image plus an expected-PC pointer predict every accepted
// word; random ready patterns, stalls, redirects, wrap, async reset and busy-time writes.
module tb_instr_fetch_unit;
  localparam int unsigned AW    = 8;
  localparam int unsigned Depth = 1 << AW;
  localparam logic [31:0] Eop   = 32'hFFFF_FFFF;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_unit_if #(.ADDR_W(AW)) bus ();

  instr_fetch_unit #(
    .ADDR_W  (AW),
    .RESET_PC(8'h00),
    .EOP_WORD(Eop)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] model_mem [Depth];
  int unsigned exp_pc   = 0;
  bit          eop_seen = 1'b0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_instr;
  logic [AW-1:0] prev_pc;
  int          n_xfer = 0, cyc = 0, first_cyc = 0, last_cyc = 0;
  logic [31:0] w_old, w_new;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rnd_word();
    logic [31:0] w;
    w = $urandom;
    return (w == Eop) ? 32'h0 : w;
  endfunction

  // One clock: drive at the negedge, check what the coming posedge will transfer.
  task automatic step(input bit rdy, input bit st = 1'b0, input bit rv = 1'b0,
                      input logic [AW-1:0] rpc = '0);
    bus.instr_ready_i  = rdy;
    bus.start          = st;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    #1;
    if (prev_stall) begin
      chk("hold_valid", 32'(bus.instr_valid_o), 32'd1);
      chk("hold_instr", bus.instr_o, prev_instr);
      chk("hold_pc", 32'(bus.instr_pc_o), 32'(prev_pc));
    end
    if (bus.instr_valid_o && rdy) begin
      chk("xfer_after_eop", 32'(eop_seen), 32'd0);
      chk("xfer_pc", 32'(bus.instr_pc_o), exp_pc);
      chk("xfer_instr", bus.instr_o, model_mem[exp_pc]);
      if (n_xfer == 0) first_cyc = cyc;
      last_cyc = cyc;
      n_xfer++;
      if (model_mem[exp_pc] == Eop) eop_seen = 1'b1;
      exp_pc = (exp_pc + 1) % Depth;
    end
    prev_stall = bus.instr_valid_o && !rdy;
    prev_instr = bus.instr_o;
    prev_pc    = bus.instr_pc_o;
    if (st || rv) begin
      exp_pc     = st ? 0 : 32'(rpc);
      eop_seen   = 1'b0;
      prev_stall = 1'b0;
      if (st) n_xfer = 0;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    bus.start          = 1'b0;
    bus.redirect_valid = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input bit honoured);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    step(1'b0);
    bus.wr_en = 1'b0;
    if (honoured) model_mem[a] = d;
  endtask

  // mode 0: ready high, 1: random ready, 2: ready low for 5 cycles mid-stream
  task automatic run(input int mode, input int budget);
    bit rdy;
    for (int i = 0; i < budget; i++) begin
      if (mode == 0)      rdy = 1'b1;
      else if (mode == 1) rdy = 1'($urandom_range(0, 1));
      else                rdy = !(i >= 4 && i < 9);
      step(rdy);
      if (bus.done_o) break;
    end
    chk("run_done", 32'(bus.done_o), 32'd1);
    chk("run_eop_seen", 32'(eop_seen), 32'd1);
    chk("done_next_cycle", 32'(cyc), 32'(last_cyc + 1));
    chk("done_valid_low", 32'(bus.instr_valid_o), 32'd0);
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.start = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
    bus.instr_ready_i = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(bus.instr_valid_o), 32'd0);
    chk("rst_instr", bus.instr_o, 32'd0);
    chk("rst_pc", 32'(bus.instr_pc_o), 32'd0);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_done", 32'(bus.done_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic program and first-word latency
    for (int a = 0; a < Depth; a++) wr(AW'(a), rnd_word(), 1'b1);
    wr(8'd0, 32'h0022_1820, 1'b1);
    wr(8'd1, 32'h0062_2022, 1'b1);
    wr(8'd2, 32'h00A6_2825, 1'b1);
    wr(8'd3, Eop, 1'b1);
    step(1'b0, 1'b1);
    chk("lat_c1_valid", 32'(bus.instr_valid_o), 32'd0);
    chk("busy_in_run", 32'(bus.busy_o), 32'd1);
    step(1'b1);
    chk("lat_c2_valid", 32'(bus.instr_valid_o), 32'd0);
    step(1'b1);
    chk("lat_c3_valid", 32'(bus.instr_valid_o), 32'd1);
    run(0, 40);
    chk("t1_count", 32'(n_xfer), 32'd4);
`ifdef FETCH_SKID_EN
    chk("t1_span", 32'(last_cyc - first_cyc), 32'd3);
`else
    chk("t1_span", 32'(last_cyc - first_cyc), 32'd6);
`endif

    // Five-cycle consumer stall mid-stream
    for (int a = 0; a < 10; a++) wr(AW'(a), rnd_word(), 1'b1);
    wr(8'd10, Eop, 1'b1);
    step(1'b0, 1'b1);
    run(2, 80);
    chk("t2_count", 32'(n_xfer), 32'd11);

    // Redirect to 0x10 with the queue full, transfer in the redirect cycle
    wr(8'd10, rnd_word(), 1'b1);
    for (int a = 16; a < 20; a++) wr(AW'(a), rnd_word(), 1'b1);
    wr(8'h14, Eop, 1'b1);
    step(1'b0, 1'b1);
    repeat (6) step(1'b0);
    step(1'b1, 1'b0, 1'b1, 8'h10);
    chk("redir_valid_low", 32'(bus.instr_valid_o), 32'd0);
    run(1, 200);
    chk("t3_count", 32'(n_xfer), 32'd6);

    // PC wrap 0xFF -> 0x00
    wr(8'hFE, rnd_word(), 1'b1);
    wr(8'hFF, rnd_word(), 1'b1);
    wr(8'h00, rnd_word(), 1'b1);
    wr(8'h01, Eop, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 8'hFE);
    run(1, 200);
    chk("t4_count", 32'(n_xfer), 32'd4);

    // Asynchronous reset mid-stream
    wr(8'h01, rnd_word(), 1'b1);
    step(1'b0, 1'b1);
    repeat (6) step(1'b1);
    chk("t5_busy_before", 32'(bus.busy_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.instr_valid_o), 32'd0);
    chk("arst_instr", bus.instr_o, 32'd0);
    chk("arst_pc", 32'(bus.instr_pc_o), 32'd0);
    chk("arst_busy", 32'(bus.busy_o), 32'd0);
    chk("arst_done", 32'(bus.done_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    prev_stall = 1'b0;
    step(1'b0);
    step(1'b0);
    chk("idle_busy", 32'(bus.busy_o), 32'd0);
    chk("idle_done", 32'(bus.done_o), 32'd0);
    chk("idle_valid", 32'(bus.instr_valid_o), 32'd0);

    // Writes dropped while busy, honoured once done
    w_old = rnd_word() & 32'h7FFF_FFFF;
    w_new = w_old ^ 32'h1;
    wr(8'd0, rnd_word(), 1'b1);
    wr(8'd1, rnd_word(), 1'b1);
    wr(8'd2, w_old, 1'b1);
    wr(8'd3, rnd_word(), 1'b1);
    wr(8'd4, rnd_word(), 1'b1);
    wr(8'd5, Eop, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0);
    step(1'b0);
    chk("t6_busy", 32'(bus.busy_o), 32'd1);
    wr(8'd2, w_new, 1'b0);
    run(0, 40);
    chk("t6_count", 32'(n_xfer), 32'd6);
    wr(8'd2, w_new, 1'b1);
    step(1'b0, 1'b1);
    run(0, 40);
    chk("t6_count2", 32'(n_xfer), 32'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
